aes_inv_cipher_core: RTL and testbench
======================================

Name: aes_inv_cipher_core

Overview:
- Iterative AES inverse cipher. Key length is set by parameter: AES-128, AES-192 or AES-256.
- Optional CBC chaining.
- Valid/ready handshakes on the input and output sides.
- Expands the key on chip, one word per cycle, into a round-key store. Then runs one inverse round per cycle.
- Sits between the host data interface and the plaintext sink. Replaces the fixed 128-bit, enable-driven decryption block.

Parameters:
- KEY_BITS, 128, key length; legal values 128/192/256. Derived: Nk = KEY_BITS/32, Nr = Nk+6, NW = 4*(Nr+1).
- CBC_EN, 0, 1 = XOR each output with the previous ciphertext (or the IV). 0 = ECB.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- key_load  in  1  single-cycle pulse; latch key, start expansion
- key  in  KEY_BITS  cipher key; w[0] = key[KEY_BITS-1 -: 32]
- key_ready  out  1  round-key store valid
- iv_load  in  1  pulse; chain register <= iv (CBC_EN=1 only)
- iv  in  128  initialisation vector
- in_valid  in  1  ciphertext valid
- in_ready  out  1  core accepts a block this cycle
- in_data  in  128  ciphertext; byte 0 at [127:120]
- out_valid  out  1  plaintext valid
- out_ready  in  1  sink accepts plaintext
- out_data  out  128  plaintext
- busy  out  1  high in KEYEXP or ROUND

Behaviour:
- Reset (async, n_rst=0):
  - State = IDLE.
  - key_ready, out_valid, busy = 0.
  - out_data, chain register, state register, counters = 0.
  - Round-key store contents are don't-care. A key must be reloaded after any reset, including reset mid-expansion or mid-decrypt.
- FSM states: IDLE, KEYEXP, ROUND.
- IDLE + key_load:
  - Go to KEYEXP. key_ready <= 0. w[0..Nk-1] <= key.
  - key_load has priority over a simultaneous in_valid and iv_load.
  - key_load is ignored outside IDLE.
- KEYEXP:
  - One word per cycle, i = Nk..NW-1.
  - w[i] = w[i-Nk] ^ f(w[i-1]), where f is:
    - RotWord+SubWord+Rcon when i mod Nk == 0;
    - SubWord only when Nk==8 and i mod Nk == 4;
    - identity otherwise.
  - Takes NW-Nk cycles (40/46/52). Then key_ready <= 1 and return to IDLE.
  - A pending out_valid block is preserved through key expansion.
- in_ready = (state==IDLE) && key_ready && !key_load && (!out_valid || out_ready).
  - Combinational.
  - Must be high in the same cycle an output handshake frees the register.
- Accept edge (in_valid && in_ready):
  - s <= in_data ^ rk[Nr]; round counter r <= Nr-1; go to ROUND.
  - CBC: ct_hold <= in_data.
- ROUND, r >= 1: s <= InvMixColumns(InvSubBytes(InvShiftRows(s)) ^ rk[r]); r <= r-1.
- ROUND, r == 0 (final round):
  - p = InvSubBytes(InvShiftRows(s)) ^ rk[0].
  - out_data <= CBC_EN ? p ^ chain : p. out_valid <= 1.
  - CBC: chain <= ct_hold.
  - Return to IDLE.
- Latency: out_valid rises Nr+1 edges after the accept edge (11/13/15). Throughput: one block per Nr+1 cycles, provided out_ready is held high.
- out_valid/out_data are held stable until out_ready is sampled high. Then out_valid <= 0, unless the final round of the next block lands on that same edge.
- iv_load is honoured only in IDLE with no in handshake that cycle; otherwise ignored. In ECB mode iv_load has no effect.
- Counters: r is 4 bits, word index is 6 bits. No wrap beyond the stated ranges; assert if reached.
- Illegal KEY_BITS fails elaboration (static assertion).

Decomposition:
- Package aes_pkg holds:
  - the state enum;
  - Nk/Nr/NW functions of KEY_BITS;
  - the Rcon table;
  - the forward S-box function (for key expansion) and inverse S-box function;
  - the xtime/gmul helpers.
- One sub-module, aes_inv_round: combinational. Inputs are state, round key and a last flag. It applies InvShiftRows, InvSubBytes, AddRoundKey and conditional InvMixColumns.
- The FSM, key expansion and handshake stay in the top.

Test Plan:
- KEY_BITS=128, key 000102…0f, expand; in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff, 11 cycles after accept; key_ready rises 40 cycles after key_load.
- KEY_BITS=192, key 000102…17, ct dda97ca4864cdfe06eaf70a0ec0d7191 -> 00112233…ff after 13 cycles. KEY_BITS=256, key 00…1f, ct 8ea2b7ca516745bfeafc49904b496089 -> 00112233…ff after 15 cycles.
- CBC_EN=1, KEY_BITS=128, iv 000102…0f, two blocks both 69c4…c55a -> 00102030405060708090a0b0c0d0e0f0 then 69d5c2eb2e2e624750541d3bbc692ba5.
- Backpressure: out_ready=0 for 20 cycles -> out_data stable, in_ready=0, second block not accepted. Raise out_ready -> in_ready high in the same cycle, and back-to-back blocks complete.
- Simultaneous key_load+in_valid in IDLE -> no accept, busy=1, key_ready=0 for 40 cycles. key_load during ROUND -> ignored, result unchanged.
- n_rst pulse mid-ROUND and mid-KEYEXP -> all outputs 0 immediately, key_ready stays 0 until a new key_load completes.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM states, key-size geometry, Rcon, GF(2^8) helpers
// and S-boxes computed arithmetically from the field inverse.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEYEXP = 2'd1,
        ST_ROUND  = 2'd2
    } aes_state_e;

    function automatic int aes_nk(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int aes_nr(input int key_bits);
        return aes_nk(key_bits) + 6;
    endfunction

    function automatic int aes_nw(input int key_bits);
        return 4 * (aes_nr(key_bits) + 1);
    endfunction

    function automatic logic [7:0] aes_rcon(input int idx);
        case (idx)
            1:       return 8'h01;
            2:       return 8'h02;
            3:       return 8'h04;
            4:       return 8'h08;
            5:       return 8'h10;
            6:       return 8'h20;
            7:       return 8'h40;
            8:       return 8'h80;
            9:       return 8'h1b;
            10:      return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // a^254 by square-and-multiply; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rk_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    logic [15:0][7:0] sub_b;
    logic [15:0][7:0] ark_b;
    logic [15:0][7:0] mix_b;

    always_comb begin
        sub_b   = '0;
        ark_b   = '0;
        mix_b   = '0;
        state_o = '0;
        // Byte 4c+r is row r of column c; row r rotates right by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sub_b[4*c+r] = inv_sbox(state_i[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8]);
            end
        end
        for (int n = 0; n < 16; n++) begin
            ark_b[n] = sub_b[n] ^ rk_i[127 - 8*n -: 8];
        end
        for (int c = 0; c < 4; c++) begin
            mix_b[4*c]   = gmul(ark_b[4*c], 8'h0e) ^ gmul(ark_b[4*c+1], 8'h0b)
                         ^ gmul(ark_b[4*c+2], 8'h0d) ^ gmul(ark_b[4*c+3], 8'h09);
            mix_b[4*c+1] = gmul(ark_b[4*c], 8'h09) ^ gmul(ark_b[4*c+1], 8'h0e)
                         ^ gmul(ark_b[4*c+2], 8'h0b) ^ gmul(ark_b[4*c+3], 8'h0d);
            mix_b[4*c+2] = gmul(ark_b[4*c], 8'h0d) ^ gmul(ark_b[4*c+1], 8'h09)
                         ^ gmul(ark_b[4*c+2], 8'h0e) ^ gmul(ark_b[4*c+3], 8'h0b);
            mix_b[4*c+3] = gmul(ark_b[4*c], 8'h0b) ^ gmul(ark_b[4*c+1], 8'h0d)
                         ^ gmul(ark_b[4*c+2], 8'h09) ^ gmul(ark_b[4*c+3], 8'h0e);
        end
        for (int n = 0; n < 16; n++) begin
            state_o[127 - 8*n -: 8] = last_i ? ark_b[n] : mix_b[n];
        end
    end

endmodule

// File: rtl/aes_inv_cipher_core.sv
// Iterative AES inverse cipher (128/192/256-bit key) with on-chip key
// expansion, optional CBC chaining and valid/ready handshakes on both sides.
module aes_inv_cipher_core
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128,
    parameter bit CBC_EN   = 1'b0
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                key_load,
    input  logic [KEY_BITS-1:0] key,
    output logic                key_ready,
    input  logic                iv_load,
    input  logic [127:0]        iv,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic                busy
);

    localparam int NK = aes_nk(KEY_BITS);
    localparam int NR = aes_nr(KEY_BITS);
    localparam int NW = aes_nw(KEY_BITS);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_inv_cipher_core: KEY_BITS must be 128, 192 or 256");
    end

    aes_state_e   state_q, state_d;
    logic         key_ready_q, key_ready_d;
    logic [5:0]   widx_q, widx_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] s_q, s_d;
    logic [127:0] ct_hold_q, ct_hold_d;
    logic [127:0] chain_q, chain_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] out_data_q, out_data_d;

    logic [31:0]  rk_mem_q [NW];

    logic         in_fire;
    logic         out_fire;
    logic         key_latch;
    logic         kx_we;
    logic [3:0]   rk_idx;
    logic [5:0]   rk_base;
    logic [127:0] rk_sel;
    logic [31:0]  kx_prev;
    logic [31:0]  kx_back;
    logic [31:0]  kx_f;
    logic [31:0]  kx_word;
    logic [127:0] round_out;

    assign in_ready  = (state_q == ST_IDLE) && key_ready_q && !key_load
                       && (!out_valid_q || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign key_latch = (state_q == ST_IDLE) && key_load;
    assign kx_we     = (state_q == ST_KEYEXP);

    assign key_ready = key_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != ST_IDLE);

    // Outside ROUND the selected key is rk[Nr], the initial whitening key.
    always_comb begin
        rk_idx  = (state_q == ST_ROUND) ? round_q : 4'(NR);
        rk_base = {rk_idx, 2'b00};
        rk_sel  = {rk_mem_q[rk_base],         rk_mem_q[rk_base + 6'd1],
                   rk_mem_q[rk_base + 6'd2],  rk_mem_q[rk_base + 6'd3]};
    end

    always_comb begin
        kx_prev = rk_mem_q[widx_q - 6'd1];
        kx_back = rk_mem_q[widx_q - 6'(NK)];
        if ((int'(widx_q) % NK) == 0) begin
            kx_f = sub_word(rot_word(kx_prev)) ^ {aes_rcon(int'(widx_q) / NK), 24'h000000};
        end else if (NK == 8 && (int'(widx_q) % NK) == 4) begin
            kx_f = sub_word(kx_prev);
        end else begin
            kx_f = kx_prev;
        end
        kx_word = kx_back ^ kx_f;
    end

    aes_inv_round u_round (
        .state_i (s_q),
        .rk_i    (rk_sel),
        .last_i  (round_q == 4'd0),
        .state_o (round_out)
    );

    always_comb begin
        state_d     = state_q;
        key_ready_d = key_ready_q;
        widx_d      = widx_q;
        round_d     = round_q;
        s_d         = s_q;
        ct_hold_d   = ct_hold_q;
        chain_d     = chain_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (out_fire) out_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (key_load) begin
                    state_d     = ST_KEYEXP;
                    key_ready_d = 1'b0;
                    widx_d      = 6'(NK);
                end else if (in_fire) begin
                    s_d     = in_data ^ rk_sel;
                    round_d = 4'(NR - 1);
                    state_d = ST_ROUND;
                    if (CBC_EN) ct_hold_d = in_data;
                end else if (iv_load && CBC_EN) begin
                    chain_d = iv;
                end
            end
            ST_KEYEXP: begin
                if (widx_q == 6'(NW - 1)) begin
                    state_d     = ST_IDLE;
                    key_ready_d = 1'b1;
                    widx_d      = 6'd0;
                end else begin
                    widx_d = widx_q + 6'd1;
                end
            end
            ST_ROUND: begin
                s_d = round_out;
                if (round_q == 4'd0) begin
                    // The output register is guaranteed free here: accept required it.
                    out_data_d  = CBC_EN ? (round_out ^ chain_q) : round_out;
                    out_valid_d = 1'b1;
                    if (CBC_EN) chain_d = ct_hold_q;
                    state_d     = ST_IDLE;
                end else begin
                    round_d = round_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            key_ready_q <= 1'b0;
            widx_q      <= '0;
            round_q     <= '0;
            s_q         <= '0;
            ct_hold_q   <= '0;
            chain_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            key_ready_q <= key_ready_d;
            widx_q      <= widx_d;
            round_q     <= round_d;
            s_q         <= s_d;
            ct_hold_q   <= ct_hold_d;
            chain_q     <= chain_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Round-key store: contents are meaningless until a key has been expanded.
    always_ff @(posedge clk) begin
        if (key_latch) begin
            for (int i = 0; i < NK; i++) begin
                rk_mem_q[i] <= key[KEY_BITS - 1 - 32*i -: 32];
            end
        end else if (kx_we) begin
            rk_mem_q[widx_q] <= kx_word;
        end
    end

    a_round_range: assert property (@(posedge clk) disable iff (!n_rst)
        (state_q == ST_ROUND) |-> (round_q <= 4'(NR - 1)));
    a_widx_range: assert property (@(posedge clk) disable iff (!n_rst)
        (state_q == ST_KEYEXP) |-> (widx_q < 6'(NW)));

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Bench for aes_inv_cipher_core: four instances (128 ECB, 192 ECB, 256 ECB,
// 128 CBC) driven with known-answer vectors; a monitor scores every output.
module tb_aes_inv_cipher_core;

    localparam int ND = 4;
    localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] IV0    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CBC_P1 = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] CBC_P2 = 128'h69d5c2eb2e2e624750541d3bbc692ba5;

    logic          clk = 1'b0;
    logic          n_rst;
    logic [ND-1:0] key_load, key_ready, iv_load, in_valid, in_ready;
    logic [ND-1:0] out_valid, out_ready, busy;
    logic [255:0]  key      [ND];
    logic [127:0]  iv       [ND];
    logic [127:0]  in_data  [ND];
    logic [127:0]  out_data [ND];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [127:0]  exp_q [ND][$];
    int            acc_q [ND][$];
    int            pres_edge [ND];
    logic [127:0]  held [ND];
    logic [ND-1:0] prev_ov, prev_hs;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int KBG = (g == 1) ? 192 : (g == 2) ? 256 : 128;
        aes_inv_cipher_core #(.KEY_BITS(KBG), .CBC_EN(g == 3)) u_dut (
            .clk       (clk),
            .n_rst     (n_rst),
            .key_load  (key_load[g]),
            .key       (key[g][KBG-1:0]),
            .key_ready (key_ready[g]),
            .iv_load   (iv_load[g]),
            .iv        (iv[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );
    end

    function automatic int nr_of(input int d);
        return (d == 1) ? 12 : (d == 2) ? 14 : 10;
    endfunction

    function automatic int kexp_of(input int d);
        return (d == 1) ? 46 : (d == 2) ? 52 : 40;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: records accept edges, and on each output handshake pops the
    // expected plaintext and checks data plus latency (edges counted
    // inclusively from the accept edge to the edge that raised out_valid).
    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (!n_rst) begin
                acc_q[d].delete();
                prev_ov[d] = 1'b0;
                prev_hs[d] = 1'b0;
            end else begin
                if (in_valid[d] && in_ready[d]) acc_q[d].push_back(cyc + 1);
                if (out_valid[d] && (!prev_ov[d] || prev_hs[d])) begin
                    pres_edge[d] = cyc;
                    held[d]      = out_data[d];
                end else if (out_valid[d]) begin
                    chk($sformatf("hold_dut%0d", d), out_data[d], held[d]);
                end
                if (out_valid[d] && out_ready[d]) begin
                    if (exp_q[d].size() == 0 || acc_q[d].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out_dut%0d got=%h want=none", d, out_data[d]);
                    end else begin
                        chk($sformatf("data_dut%0d", d), out_data[d], exp_q[d].pop_front());
                        chk($sformatf("latency_dut%0d", d),
                            128'(pres_edge[d] - acc_q[d].pop_front() + 1), 128'(nr_of(d) + 1));
                    end
                end
                prev_ov[d] = out_valid[d];
                prev_hs[d] = out_valid[d] && out_ready[d];
            end
        end
    end

    task automatic load_key(input int d, input logic [255:0] k, input bit check_lat);
        int n;
        key[d]      = k;
        key_load[d] = 1'b1;
        tick();
        key_load[d] = 1'b0;
        n = 0;
        while (!key_ready[d] && n < 200) begin
            tick();
            n++;
        end
        if (check_lat) chk($sformatf("keyexp_cycles_dut%0d", d), 128'(n), 128'(kexp_of(d)));
    endtask

    task automatic send(input int d, input logic [127:0] ct, input logic [127:0] want, input bit push);
        int n;
        n = 0;
        if (push) exp_q[d].push_back(want);
        in_data[d]  = ct;
        in_valid[d] = 1'b1;
        @(negedge clk);
        while (!in_ready[d] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[d]) begin
            total++;
            bad++;
            $display("FAIL send_timeout_dut%0d got=in_ready_low want=accept", d);
        end
        tick();
        in_valid[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while ((busy[d] || out_valid[d]) && n < 300) begin
            tick();
            n++;
        end
        chk($sformatf("idle_dut%0d", d), 128'(busy[d] || out_valid[d]), 128'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 128'(out_valid[0]), 128'(0));
        chk({tag, "_key_ready"}, 128'(key_ready[0]), 128'(0));
        chk({tag, "_busy"},      128'(busy[0]),      128'(0));
        chk({tag, "_out_data"},  out_data[0],        128'(0));
        chk({tag, "_in_ready"},  128'(in_ready[0]),  128'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst     = 1'b0;
        key_load  = '0;
        iv_load   = '0;
        in_valid  = '0;
        out_ready = '1;
        for (int d = 0; d < ND; d++) begin
            key[d]     = '0;
            iv[d]      = '0;
            in_data[d] = '0;
        end
        repeat (3) tick();

        for (int d = 0; d < ND; d++) begin
            chk($sformatf("rst_key_ready%0d", d), 128'(key_ready[d]), 128'(0));
            chk($sformatf("rst_out_valid%0d", d), 128'(out_valid[d]), 128'(0));
            chk($sformatf("rst_busy%0d", d),      128'(busy[d]),      128'(0));
            chk($sformatf("rst_out_data%0d", d),  out_data[d],        128'(0));
            chk($sformatf("rst_in_ready%0d", d),  128'(in_ready[d]),  128'(0));
        end
        n_rst = 1'b1;
        tick();

        load_key(0, K128, 1'b1);
        load_key(1, K192, 1'b1);
        load_key(2, K256, 1'b1);
        load_key(3, K128, 1'b1);

        send(0, CT128, PT, 1'b1);
        send(1, CT192, PT, 1'b1);
        send(2, CT256, PT, 1'b1);

        iv[3]      = IV0;
        iv_load[3] = 1'b1;
        tick();
        iv_load[3] = 1'b0;
        send(3, CT128, CBC_P1, 1'b1);
        send(3, CT128, CBC_P2, 1'b1);
        for (int d = 0; d < ND; d++) wait_idle(d);

        // Backpressure: hold the first result, second block must wait.
        out_ready[0] = 1'b0;
        send(0, CT128, PT, 1'b1);
        begin
            int n;
            n = 0;
            while (!out_valid[0] && n < 100) begin
                tick();
                n++;
            end
        end
        in_data[0]  = CT128;
        in_valid[0] = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("bp_in_ready",  128'(in_ready[0]),  128'(0));
            chk("bp_out_valid", 128'(out_valid[0]), 128'(1));
            chk("bp_out_data",  out_data[0],        PT);
            tick();
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 128'(in_ready[0]), 128'(1));
        exp_q[0].push_back(PT);
        tick();
        in_valid[0] = 1'b0;
        send(0, CT128, PT, 1'b1);
        send(0, CT128, PT, 1'b1);
        wait_idle(0);

        // key_load together with in_valid: key wins, no accept.
        key[0]      = K128;
        key_load[0] = 1'b1;
        in_data[0]  = CT128;
        in_valid[0] = 1'b1;
        @(negedge clk);
        chk("kl_in_ready", 128'(in_ready[0]), 128'(0));
        tick();
        key_load[0] = 1'b0;
        in_valid[0] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("kl_busy",      128'(busy[0]),      128'(1));
            chk("kl_key_ready", 128'(key_ready[0]), 128'(0));
            tick();
        end
        @(negedge clk);
        chk("kl_done_key_ready", 128'(key_ready[0]), 128'(1));
        chk("kl_done_busy",      128'(busy[0]),      128'(0));
        tick();

        // key_load during ROUND is ignored.
        send(0, CT128, PT, 1'b1);
        repeat (3) tick();
        key[0]      = '1;
        key_load[0] = 1'b1;
        tick();
        key_load[0] = 1'b0;
        key[0]      = K128;
        wait_idle(0);
        chk("round_kl_key_ready", 128'(key_ready[0]), 128'(1));
        send(0, CT128, PT, 1'b1);
        wait_idle(0);

        // Reset mid-ROUND: outputs clear at once, aborted block never appears.
        send(0, CT128, PT, 1'b0);
        repeat (4) tick();
        #2;
        n_rst = 1'b0;
        #1;
        check_reset_outputs("rst_round");
        tick();
        n_rst = 1'b1;
        repeat (20) tick();
        chk("post_rst_key_ready", 128'(key_ready[0]), 128'(0));
        chk("post_rst_in_ready",  128'(in_ready[0]),  128'(0));

        // Reset mid-KEYEXP: expansion must not resume on its own.
        key[0]      = K128;
        key_load[0] = 1'b1;
        tick();
        key_load[0] = 1'b0;
        repeat (10) tick();
        #2;
        n_rst = 1'b0;
        #1;
        check_reset_outputs("rst_keyexp");
        tick();
        n_rst = 1'b1;
        repeat (60) tick();
        chk("post_kx_rst_key_ready", 128'(key_ready[0]), 128'(0));
        chk("post_kx_rst_busy",      128'(busy[0]),      128'(0));

        load_key(0, K128, 1'b1);
        send(0, CT128, PT, 1'b1);
        wait_idle(0);

        repeat (10) tick();
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("scoreboard_empty%0d", d), 128'(exp_q[d].size()), 128'(0));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
